// File: rtl/axis_arb_pkg.sv
// Shared types for the frame-granular AXI-Stream arbiter.
// The FLUSH state exists only when AXIS_ARB_FRAME_TIMEOUT_EN is defined.
package axis_arb_pkg;

`ifdef AXIS_ARB_FRAME_TIMEOUT_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } arb_state_e;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1
  } arb_state_e;
`endif

  localparam int unsigned STALL_CNT_W = 16;

  // Index width for a port pointer; a single port still needs one bit.
  function automatic int unsigned ptr_width(input int unsigned ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/axis_rr_grant.sv
// Combinational rotating-priority encoder: first requester at or after prio_ptr,
// wrapping modulo PORTS.
module axis_rr_grant
  import axis_arb_pkg::*;
#(
  parameter int unsigned PORTS = 4,
  parameter int unsigned PTR_W = ptr_width(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [PTR_W-1:0] prio_ptr,
  output logic [PTR_W-1:0] winner,
  output logic             any_req
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    winner  = prio_ptr;
    any_req = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      sum = {1'b0, prio_ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(PORTS)) begin
        sum = sum - (PTR_W+1)'(PORTS);
      end
      idx = PTR_W'(sum);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-granular round-robin AXI-Stream merger with a registered output stage.
// Define AXIS_ARB_FRAME_TIMEOUT_EN to abort frames whose source stalls for TIMEOUT_CYCLES.
module axis_frame_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned PORTS      = 4,
  parameter int unsigned DATA_WIDTH = 8
`ifdef AXIS_ARB_FRAME_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PORTS*DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [PORTS-1:0]            input_axis_tvalid,
  output logic [PORTS-1:0]            input_axis_tready,
  input  logic [PORTS-1:0]            input_axis_tlast,
  input  logic [PORTS-1:0]            input_axis_tuser,
  output logic [DATA_WIDTH-1:0]       output_axis_tdata,
  output logic                        output_axis_tvalid,
  input  logic                        output_axis_tready,
  output logic                        output_axis_tlast,
  output logic                        output_axis_tuser
);

  localparam int unsigned PTR_W = ptr_width(PORTS);

  arb_state_e             state_q, state_d;
  logic [PTR_W-1:0]       prio_ptr_q, prio_ptr_d;
  logic [PTR_W-1:0]       grant_q, grant_d;
  logic                   out_tvalid_q, out_tvalid_d;
  logic [DATA_WIDTH-1:0]  out_tdata_q, out_tdata_d;
  logic                   out_tlast_q, out_tlast_d;
  logic                   out_tuser_q, out_tuser_d;

  logic [DATA_WIDTH-1:0]  in_data [PORTS];
  logic [PTR_W-1:0]       arb_winner;
  logic                   arb_any;
  logic                   sel_tvalid, sel_tlast, sel_tuser;
  logic [DATA_WIDTH-1:0]  sel_tdata;
  logic                   out_free;
  logic [PTR_W-1:0]       grant_inc;

`ifdef AXIS_ARB_FRAME_TIMEOUT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
`endif

  for (genvar g = 0; g < PORTS; g++) begin : g_unpack
    assign in_data[g] = input_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  axis_rr_grant #(
    .PORTS (PORTS),
    .PTR_W (PTR_W)
  ) u_rr_grant (
    .req      (input_axis_tvalid),
    .prio_ptr (prio_ptr_q),
    .winner   (arb_winner),
    .any_req  (arb_any)
  );

  assign sel_tvalid = input_axis_tvalid[grant_q];
  assign sel_tlast  = input_axis_tlast[grant_q];
  assign sel_tuser  = input_axis_tuser[grant_q];
  assign sel_tdata  = in_data[grant_q];
  // Output slot can take a beat if empty or draining this cycle.
  assign out_free   = output_axis_tready | ~out_tvalid_q;
  assign grant_inc  = (grant_q == PTR_W'(PORTS - 1)) ? '0 : grant_q + PTR_W'(1);

  always_comb begin
    state_d           = state_q;
    prio_ptr_d        = prio_ptr_q;
    grant_d           = grant_q;
    out_tvalid_d      = out_tvalid_q & ~output_axis_tready;
    out_tdata_d       = out_tdata_q;
    out_tlast_d       = out_tlast_q;
    out_tuser_d       = out_tuser_q;
    input_axis_tready = '0;
`ifdef AXIS_ARB_FRAME_TIMEOUT_EN
    stall_cnt_d       = '0;
`endif
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d = arb_winner;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        input_axis_tready[grant_q] = out_free;
        if (sel_tvalid && out_free) begin
          out_tvalid_d = 1'b1;
          out_tdata_d  = sel_tdata;
          out_tlast_d  = sel_tlast;
          out_tuser_d  = sel_tuser;
          if (sel_tlast) begin
            state_d    = IDLE;
            prio_ptr_d = grant_inc;
          end
        end
`ifdef AXIS_ARB_FRAME_TIMEOUT_EN
        else if (!sel_tvalid) begin
          stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
          if (stall_cnt_q == STALL_CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = FLUSH;
          end
        end else begin
          stall_cnt_d = stall_cnt_q;
        end
`endif
      end
`ifdef AXIS_ARB_FRAME_TIMEOUT_EN
      // Terminate the stalled frame with an error-flagged empty last beat.
      FLUSH: begin
        if (out_free) begin
          out_tvalid_d = 1'b1;
          out_tdata_d  = '0;
          out_tlast_d  = 1'b1;
          out_tuser_d  = 1'b1;
          state_d      = IDLE;
          prio_ptr_d   = grant_inc;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prio_ptr_q   <= '0;
      grant_q      <= '0;
      out_tvalid_q <= 1'b0;
      out_tdata_q  <= '0;
      out_tlast_q  <= 1'b0;
      out_tuser_q  <= 1'b0;
`ifdef AXIS_ARB_FRAME_TIMEOUT_EN
      stall_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      prio_ptr_q   <= prio_ptr_d;
      grant_q      <= grant_d;
      out_tvalid_q <= out_tvalid_d;
      out_tdata_q  <= out_tdata_d;
      out_tlast_q  <= out_tlast_d;
      out_tuser_q  <= out_tuser_d;
`ifdef AXIS_ARB_FRAME_TIMEOUT_EN
      stall_cnt_q  <= stall_cnt_d;
`endif
    end
  end

  assign output_axis_tvalid = out_tvalid_q;
  assign output_axis_tdata  = out_tdata_q;
  assign output_axis_tlast  = out_tlast_q;
  assign output_axis_tuser  = out_tuser_q;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Self-checking bench for axis_frame_arbiter: per-port source queues, output scoreboard,
// table of single-requester frames plus hand-written contention/stall/reset sequences.
module tb_axis_frame_arbiter;

  localparam int unsigned PORTS = 4;
  localparam int unsigned DW    = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
  } beat_t;

  typedef struct {
    int          port;
    int          len;
    logic [7:0]  d0;
    logic        user;
    int          exp_lat;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [PORTS*DW-1:0]  in_tdata;
  logic [PORTS-1:0]     in_tvalid;
  logic [PORTS-1:0]     in_tready;
  logic [PORTS-1:0]     in_tlast;
  logic [PORTS-1:0]     in_tuser;
  logic [DW-1:0]        out_tdata;
  logic                 out_tvalid;
  logic                 out_tready;
  logic                 out_tlast;
  logic                 out_tuser;

  beat_t       src_mem [PORTS][256];
  int unsigned src_wr [PORTS];
  int unsigned src_rd [PORTS];
  int          src_start_cyc [PORTS];
  int          flush_gen = 0;
  beat_t       exp_q [$];
  int          hs_cyc_q [$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  vec_t        vecs [6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_frame_arbiter #(
    .PORTS      (PORTS),
    .DATA_WIDTH (DW)
`ifdef AXIS_ARB_FRAME_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (8)
`endif
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .input_axis_tdata   (in_tdata),
    .input_axis_tvalid  (in_tvalid),
    .input_axis_tready  (in_tready),
    .input_axis_tlast   (in_tlast),
    .input_axis_tuser   (in_tuser),
    .output_axis_tdata  (out_tdata),
    .output_axis_tvalid (out_tvalid),
    .output_axis_tready (out_tready),
    .output_axis_tlast  (out_tlast),
    .output_axis_tuser  (out_tuser)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_frame(input int port, input int len, input logic [7:0] d0,
                            input logic user, input logic close);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = 8'(d0 + 8'(k));
      b.last = close && (k == len - 1);
      b.user = user;
      src_mem[port][src_wr[port] % 256] = b;
      src_wr[port]++;
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_tvalid) && n < budget) begin
      step();
      n++;
    end
    tests++;
    if (exp_q.size() != 0 || out_tvalid) begin
      fails++;
      $display("FAIL %s_drain: %0d beats still expected after %0d cycles", name, exp_q.size(), n);
    end
    step();
    step();
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    flush_gen++;
    exp_q.delete();
    #1;
    check("rst_out_tvalid", 32'(out_tvalid), 32'd0);
    check("rst_out_tdata",  32'(out_tdata),  32'd0);
    check("rst_out_tlast",  32'(out_tlast),  32'd0);
    check("rst_out_tuser",  32'(out_tuser),  32'd0);
    check("rst_in_tready",  32'(in_tready),  32'd0);
    step();
    step();
    hs_cyc_q.delete();
    rst_n = 1'b1;
  endtask

  // Source driver: retire beats handshaken at the previous edge, present the next one.
  initial begin
    logic [PORTS-1:0] hs;
    int               flush_seen;
    flush_seen = 0;
    in_tvalid  = '0;
    in_tdata   = '0;
    in_tlast   = '0;
    in_tuser   = '0;
    for (int i = 0; i < PORTS; i++) begin
      src_wr[i] = 0;
      src_rd[i] = 0;
      src_start_cyc[i] = 0;
    end
    forever begin
      @(negedge clk);
      hs = in_tvalid & in_tready;
      @(posedge clk);
      #1;
      if (flush_seen != flush_gen) begin
        flush_seen = flush_gen;
        hs = '0;
        for (int i = 0; i < PORTS; i++) src_rd[i] = src_wr[i];
      end
      for (int i = 0; i < PORTS; i++) begin
        if (hs[i]) src_rd[i]++;
        if (src_rd[i] != src_wr[i]) begin
          if (!in_tvalid[i]) src_start_cyc[i] = cyc;
          in_tvalid[i]          = 1'b1;
          in_tdata[i*DW +: DW]  = src_mem[i][src_rd[i] % 256].data;
          in_tlast[i]           = src_mem[i][src_rd[i] % 256].last;
          in_tuser[i]           = src_mem[i][src_rd[i] % 256].user;
        end else begin
          in_tvalid[i] = 1'b0;
        end
      end
    end
  end

  // Output monitor: every accepted output beat is popped and compared.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && out_tvalid && out_tready) begin
      hs_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got data 0x%0h last %0b, expected no beat", out_tdata, out_tlast);
      end else begin
        e = exp_q.pop_front();
        check("out_tdata", 32'(out_tdata), 32'(e.data));
        check("out_tlast", 32'(out_tlast), 32'(e.last));
        check("out_tuser", 32'(out_tuser), 32'(e.user));
      end
    end
  end

  initial begin
    int   exp_off [4];
    int   start;
    logic [DW-1:0] held;
    rst_n      = 1'b0;
    out_tready = 1'b1;

    vecs[0] = '{port: 2, len: 3, d0: 8'hA1, user: 1'b0, exp_lat: 2};
    vecs[1] = '{port: 0, len: 1, d0: 8'h55, user: 1'b1, exp_lat: 2};
    vecs[2] = '{port: 3, len: 4, d0: 8'hF0, user: 1'b0, exp_lat: 2};
    vecs[3] = '{port: 1, len: 2, d0: 8'h0F, user: 1'b1, exp_lat: 2};
    vecs[4] = '{port: 2, len: 1, d0: 8'hFF, user: 1'b0, exp_lat: 2};
    vecs[5] = '{port: 0, len: 5, d0: 8'h30, user: 1'b1, exp_lat: 2};

    do_reset();

    // Single-requester frames: fixed 2-cycle latency, then one beat per cycle.
    for (int v = 0; v < 6; v++) begin
      hs_cyc_q.delete();
      push_frame(vecs[v].port, vecs[v].len, vecs[v].d0, vecs[v].user, 1'b1);
      wait_drain("vec", 40);
      check("vec_beats", 32'(hs_cyc_q.size()), 32'(vecs[v].len));
      if (hs_cyc_q.size() == vecs[v].len) begin
        check("vec_latency", 32'(hs_cyc_q[0] - src_start_cyc[vecs[v].port]), 32'(vecs[v].exp_lat));
        for (int k = 1; k < vecs[v].len; k++) begin
          check("vec_spacing", 32'(hs_cyc_q[k] - hs_cyc_q[k-1]), 32'd1);
        end
      end
    end

    // After a port 2 frame, port 3 outranks port 0.
    do_reset();
    push_frame(2, 3, 8'hA1, 1'b0, 1'b1);
    wait_drain("prio_a", 40);
    push_frame(3, 1, 8'h33, 1'b0, 1'b1);
    push_frame(0, 1, 8'h03, 1'b0, 1'b1);
    wait_drain("prio_b", 40);

    // Ports 0 and 1 from reset: whole frames, one bubble between them.
    do_reset();
    push_frame(0, 2, 8'h10, 1'b0, 1'b1);
    push_frame(1, 2, 8'h20, 1'b1, 1'b1);
    wait_drain("two_port", 40);
    exp_off = '{2, 3, 5, 6};
    check("two_port_beats", 32'(hs_cyc_q.size()), 32'd4);
    if (hs_cyc_q.size() == 4) begin
      start = src_start_cyc[0];
      for (int k = 0; k < 4; k++) begin
        check("two_port_timing", 32'(hs_cyc_q[k] - start), 32'(exp_off[k]));
      end
    end

    // Four ports always valid with 1-beat frames: strict 0,1,2,3 rotation.
    do_reset();
    for (int s = 0; s < 50; s++) begin
      for (int p = 0; p < 4; p++) begin
        push_frame(p, 1, 8'(p * 64 + s), 1'(s), 1'b1);
      end
    end
    wait_drain("fair", 500);
    check("fair_beats", 32'(hs_cyc_q.size()), 32'd200);
    if (hs_cyc_q.size() == 200) begin
      check("fair_first", 32'(hs_cyc_q[0] - src_start_cyc[0]), 32'd2);
      check("fair_span", 32'(hs_cyc_q[199] - hs_cyc_q[0]), 32'd398);
    end

    // Downstream stall mid-frame: output held, granted source blocked.
    do_reset();
    push_frame(2, 6, 8'h60, 1'b1, 1'b1);
    for (int n = 0; n < 20 && hs_cyc_q.size() < 2; n++) step();
    out_tready = 1'b0;
    held = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 0) held = out_tdata;
      else check("stall_tdata", 32'(out_tdata), 32'(held));
      check("stall_tvalid", 32'(out_tvalid), 32'd1);
      check("stall_in_tready", 32'(in_tready), 32'd0);
    end
    out_tready = 1'b1;
    wait_drain("stall", 40);

    // Reset mid-frame on port 1 with prio_ptr=1; afterwards port 0 must win.
    do_reset();
    push_frame(0, 1, 8'h01, 1'b0, 1'b1);
    wait_drain("rst_pre", 40);
    hs_cyc_q.delete();
    push_frame(1, 6, 8'h80, 1'b0, 1'b1);
    for (int n = 0; n < 20 && hs_cyc_q.size() < 3; n++) step();
    check("rst_mid_progress", 32'(hs_cyc_q.size()), 32'd3);
    do_reset();
    push_frame(0, 2, 8'h40, 1'b1, 1'b1);
    push_frame(1, 2, 8'h90, 1'b0, 1'b1);
    wait_drain("rst_post", 40);

`ifdef AXIS_ARB_FRAME_TIMEOUT_EN
    // Port 3 stalls after 2 beats: aborted with an error beat, then port 0 served.
    do_reset();
    push_frame(3, 2, 8'h31, 1'b0, 1'b0);
    exp_q.push_back(beat_t'({8'h00, 1'b1, 1'b1}));
    step();
    push_frame(0, 1, 8'h0A, 1'b0, 1'b1);
    wait_drain("timeout", 60);
    check("timeout_beats", 32'(hs_cyc_q.size()), 32'd4);
    if (hs_cyc_q.size() == 4) begin
      check("timeout_gap", 32'(hs_cyc_q[2] - hs_cyc_q[1]), 32'd9);
    end
    push_frame(3, 1, 8'h3C, 1'b0, 1'b1);
    wait_drain("timeout_rest", 40);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
